// File: rtl/a_row_loader_if.sv
// a_row_loader_if: handshake and bus bundle between the A-row loader and its environment.
// Ports carried:
//   i_start / i_a_rows / i_a_cols_div_t  matrix start pulse and sizes
//   i_elem / i_elem_valid / o_elem_ready element stream from the generator
//   i_mem_sel / o_a_ready                multiplier buffer select and row-ready
//   o_wr_en_1 / o_wr_en_2 / o_wr_addr / o_wr_data  ping-pong row SRAM write port
//   o_busy / o_done                      status
// master: environment side (drives i_*); slave: loader side (drives o_*).
interface a_row_loader_if #(
   parameter int unsigned A_ROWS        = 1344,
   parameter int unsigned A_COLS        = 1344,
   parameter int unsigned ELEMENT_WIDTH = 16,
   parameter int unsigned T             = 4,
   parameter int unsigned WORD_SIZE     = ELEMENT_WIDTH * T
);
   localparam int unsigned ROW_W  = $clog2(A_ROWS) + 1;
   localparam int unsigned COL_W  = $clog2(A_COLS / T);
   localparam int unsigned ADDR_W = $clog2(A_COLS * ELEMENT_WIDTH / WORD_SIZE);

   logic                     i_start;
   logic [ROW_W-1:0]         i_a_rows;
   logic [COL_W-1:0]         i_a_cols_div_t;
   logic [ELEMENT_WIDTH-1:0] i_elem;
   logic                     i_elem_valid;
   logic                     o_elem_ready;
   logic                     i_mem_sel;
   logic                     o_a_ready;
   logic                     o_wr_en_1;
   logic                     o_wr_en_2;
   logic [ADDR_W-1:0]        o_wr_addr;
   logic [WORD_SIZE-1:0]     o_wr_data;
   logic                     o_busy;
   logic                     o_done;

   modport master (
      output i_start, i_a_rows, i_a_cols_div_t, i_elem, i_elem_valid, i_mem_sel,
      input  o_elem_ready, o_a_ready, o_wr_en_1, o_wr_en_2, o_wr_addr, o_wr_data, o_busy, o_done
   );

   modport slave (
      input  i_start, i_a_rows, i_a_cols_div_t, i_elem, i_elem_valid, i_mem_sel,
      output o_elem_ready, o_a_ready, o_wr_en_1, o_wr_en_2, o_wr_addr, o_wr_data, o_busy, o_done
   );
endinterface

// File: rtl/a_row_loader.sv
// a_row_loader: packs a stream of A-matrix elements (T per word, first element in the MSBs)
// and writes each row into whichever of two ping-pong row SRAMs the multiplier is not reading.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   a_bus    a_row_loader_if.slave: start/sizes, element stream, multiplier select/ready,
//            row SRAM write port, busy/done status
module a_row_loader #(
   parameter int unsigned A_ROWS        = 1344,
   parameter int unsigned A_COLS        = 1344,
   parameter int unsigned ELEMENT_WIDTH = 16,
   parameter int unsigned T             = 4,
   parameter int unsigned WORD_SIZE     = ELEMENT_WIDTH * T
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   a_row_loader_if.slave a_bus
);
   localparam int unsigned ROW_W  = $clog2(A_ROWS) + 1;
   localparam int unsigned COL_W  = $clog2(A_COLS / T);
   localparam int unsigned ADDR_W = $clog2(A_COLS * ELEMENT_WIDTH / WORD_SIZE);
   localparam int unsigned E_W    = (T > 1) ? $clog2(T) : 1;

   typedef enum logic [1:0] {StIdle, StFill, StWait, StDone} state_e;

   state_e               r_state, w_state_d;
   logic [WORD_SIZE-1:0] r_pk;
   logic [E_W-1:0]       r_e_cnt;
   logic [ADDR_W-1:0]    r_w_cnt;
   logic [ROW_W-1:0]     r_r_cnt, r_rows;
   logic [COL_W-1:0]     r_cols;
   logic [1:0]           r_full, w_full_d;
   logic                 r_wr_sel, r_prev_sel, r_wr_pend;
   logic                 w_accept, w_commit, w_last_row, w_release, w_elem_ready, w_done;

   assign w_accept   = a_bus.i_elem_valid && w_elem_ready;
   // A pending write of the last word of a row is the commit cycle.
   assign w_commit   = r_wr_pend && (r_w_cnt == (ADDR_W'(r_cols) - ADDR_W'(1)));
   assign w_last_row = ((r_r_cnt + ROW_W'(1)) == r_rows);
   assign w_release  = (a_bus.i_mem_sel != r_prev_sel);

   // Release first, commit second: a commit on the other buffer in the same cycle survives.
   always_comb begin
      w_full_d = r_full;
      if (w_release) w_full_d[r_prev_sel] = 1'b0;
      if (w_commit)  w_full_d[r_wr_sel]   = 1'b1;
   end

   always_comb begin
      w_state_d    = r_state;
      w_elem_ready = 1'b0;
      w_done       = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (a_bus.i_start) w_state_d = StFill;
         end
         StFill: begin
            w_elem_ready = !r_full[r_wr_sel] && !w_commit;
            if (w_commit) begin
               if (w_last_row)                w_state_d = StDone;
               else if (w_full_d[~r_wr_sel])  w_state_d = StWait;
            end
         end
         StWait: begin
            // Leave as soon as the target buffer's full bit is seen clearing.
            if (!w_full_d[r_wr_sel]) w_state_d = StFill;
         end
         StDone: begin
            w_done    = 1'b1;
            w_state_d = StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= StIdle;
         r_pk       <= '0;
         r_e_cnt    <= '0;
         r_w_cnt    <= '0;
         r_r_cnt    <= '0;
         r_rows     <= '0;
         r_cols     <= '0;
         r_full     <= '0;
         r_wr_sel   <= 1'b0;
         r_prev_sel <= 1'b0;
         r_wr_pend  <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_prev_sel <= a_bus.i_mem_sel;
         r_full     <= w_full_d;
         r_wr_pend  <= 1'b0;
         if (r_state == StIdle && a_bus.i_start) begin
            r_rows     <= a_bus.i_a_rows;
            r_cols     <= a_bus.i_a_cols_div_t;
            r_pk       <= '0;
            r_e_cnt    <= '0;
            r_w_cnt    <= '0;
            r_r_cnt    <= '0;
            r_full     <= '0;
            r_wr_sel   <= 1'b0;
            r_prev_sel <= 1'b0;
         end else begin
            if (w_accept) begin
               r_pk <= {r_pk[WORD_SIZE-ELEMENT_WIDTH-1:0], a_bus.i_elem};
               if (r_e_cnt == E_W'(T - 1)) begin
                  r_e_cnt   <= '0;
                  r_wr_pend <= 1'b1;
               end else begin
                  r_e_cnt <= r_e_cnt + E_W'(1);
               end
            end
            if (r_wr_pend) begin
               if (w_commit) begin
                  r_w_cnt  <= '0;
                  r_wr_sel <= ~r_wr_sel;
                  r_r_cnt  <= r_r_cnt + ROW_W'(1);
               end else begin
                  r_w_cnt <= r_w_cnt + ADDR_W'(1);
               end
            end
         end
      end
   end

   // Write port is driven straight from registers, so reset drops strobes immediately.
   assign a_bus.o_wr_en_1    = r_wr_pend && !r_wr_sel;
   assign a_bus.o_wr_en_2    = r_wr_pend && r_wr_sel;
   assign a_bus.o_wr_addr    = r_wr_pend ? r_w_cnt : '0;
   assign a_bus.o_wr_data    = r_wr_pend ? r_pk : '0;
   assign a_bus.o_a_ready    = r_full[a_bus.i_mem_sel];
   assign a_bus.o_elem_ready = w_elem_ready;
   assign a_bus.o_busy       = (r_state != StIdle);
   assign a_bus.o_done       = w_done;
endmodule

// File: tb/tb_a_row_loader.sv
// tb_a_row_loader: directed bench for a_row_loader with a cycle-level behavioural model
// (element count, buffer fullness, expected words) checked against the DUT every cycle.
module tb_a_row_loader;
   localparam int A_ROWS = 1344;
   localparam int A_COLS = 1344;
   localparam int EW     = 16;
   localparam int TT     = 4;
   localparam int WS     = EW * TT;
   localparam int ROW_W  = $clog2(A_ROWS) + 1;
   localparam int COL_W  = $clog2(A_COLS / TT);

   logic i_clk;
   logic i_rst_n;

   a_row_loader_if #(
      .A_ROWS(A_ROWS), .A_COLS(A_COLS), .ELEMENT_WIDTH(EW), .T(TT), .WORD_SIZE(WS)
   ) bus ();

   a_row_loader #(
      .A_ROWS(A_ROWS), .A_COLS(A_COLS), .ELEMENT_WIDTH(EW), .T(TT), .WORD_SIZE(WS)
   ) dut (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .a_bus  (bus)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
   endtask

   typedef struct {
      int          bufn;
      int          addr;
      logic [63:0] data;
   } wr_t;
   wr_t wlog[$];

   // Behavioural model state
   logic        m_busy = 1'b0, m_done_exp = 1'b0, m_pend = 1'b0, m_pend_sel = 1'b0;
   logic        m_sel = 1'b0, m_prev = 1'b0;
   logic [1:0]  m_full = 2'b00;
   logic [63:0] m_word = '0, m_pend_data = '0;
   int          m_rows = 0, m_cols = 0, m_e = 0, m_w = 0, m_r = 0, m_pend_addr = 0;
   int          acc_cnt = 0, done_cnt = 0;

   always @(negedge i_clk) begin : mon
      logic commit_now, exp_ready, nxt_pend, was_idle;
      if (!i_rst_n) begin
         m_busy = 0; m_done_exp = 0; m_pend = 0; m_full = 0; m_sel = 0; m_prev = 0;
         m_e = 0; m_w = 0; m_r = 0; m_word = '0;
      end else begin
         commit_now = m_pend && (m_pend_addr == m_cols - 1);
         exp_ready  = m_busy && !m_done_exp && !m_full[m_sel] && !commit_now;
         chk("elem_ready", 64'(bus.o_elem_ready), 64'(exp_ready));
         chk("a_ready", 64'(bus.o_a_ready), 64'(m_full[bus.i_mem_sel]));
         chk("busy", 64'(bus.o_busy), 64'(m_busy));
         chk("done", 64'(bus.o_done), 64'(m_done_exp));
         chk("wr_en_1", 64'(bus.o_wr_en_1), 64'(m_pend && !m_pend_sel));
         chk("wr_en_2", 64'(bus.o_wr_en_2), 64'(m_pend && m_pend_sel));
         chk("wr_to_full", 64'((bus.o_wr_en_1 && m_full[0]) || (bus.o_wr_en_2 && m_full[1])),
             64'(0));
         if (m_pend) begin
            chk("wr_addr", 64'(bus.o_wr_addr), 64'(m_pend_addr));
            chk("wr_data", bus.o_wr_data, m_pend_data);
         end
         if (bus.o_wr_en_1 || bus.o_wr_en_2)
            wlog.push_back('{bufn: bus.o_wr_en_2 ? 2 : 1, addr: int'(bus.o_wr_addr),
                             data: bus.o_wr_data});
         if (bus.o_done) done_cnt++;

         was_idle = !m_busy;
         nxt_pend = 0;
         if (bus.i_elem_valid && bus.o_elem_ready) begin
            acc_cnt++;
            m_word = {m_word[WS-EW-1:0], bus.i_elem};
            m_e++;
            if (m_e == TT) begin m_e = 0; nxt_pend = 1; end
         end
         if (bus.i_mem_sel != m_prev) m_full[m_prev] = 1'b0;
         m_prev = bus.i_mem_sel;
         if (m_done_exp) begin m_done_exp = 0; m_busy = 0; end
         if (commit_now) begin
            m_full[m_pend_sel] = 1'b1;
            m_sel = !m_sel;
            m_w = 0;
            m_r++;
            m_done_exp = (m_r == m_rows);
         end else if (m_pend) begin
            m_w++;
         end
         if (nxt_pend) begin
            m_pend_data = m_word; m_pend_addr = m_w; m_pend_sel = m_sel;
         end
         m_pend = nxt_pend;
         if (was_idle && bus.i_start) begin
            m_busy = 1; m_full = 0; m_sel = 0; m_prev = 0; m_e = 0; m_w = 0; m_r = 0;
            m_pend = 0; m_word = '0; acc_cnt = 0;
            m_rows = int'(bus.i_a_rows); m_cols = int'(bus.i_a_cols_div_t);
         end
      end
   end

   task automatic do_start(input int rows, input int cols);
      bus.i_a_rows = ROW_W'(rows);
      bus.i_a_cols_div_t = COL_W'(cols);
      bus.i_start = 1'b1;
      @(posedge i_clk); #1;
      bus.i_start = 1'b0;
   endtask

   // Offer n elements base..base+n-1; toggles i_mem_sel right after element toggle_at is taken.
   task automatic feed(input int n, input int base, input bit gaps, input int toggle_at,
                       input int budget, output int cyc);
      int  idx;
      logic acc;
      idx = 0;
      cyc = 0;
      while (idx < n && cyc < budget) begin
         bus.i_elem = EW'(base + idx);
         bus.i_elem_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
         @(negedge i_clk);
         acc = bus.i_elem_valid && bus.o_elem_ready;
         @(posedge i_clk); #1;
         cyc++;
         if (acc) begin
            idx++;
            if (idx == toggle_at) bus.i_mem_sel = ~bus.i_mem_sel;
         end
      end
      bus.i_elem_valid = 1'b0;
      chk("feed_count", 64'(idx), 64'(n));
   endtask

   task automatic wait_done(output int k);
      k = 0;
      do begin @(negedge i_clk); k++; end while (!bus.o_done && k < 200);
      @(posedge i_clk); #1;
   endtask

   task automatic chk_wr(input string nm, input int i, input int b, input int a,
                         input logic [63:0] d);
      if (i < wlog.size()) begin
         chk({nm, "_buf"}, 64'(wlog[i].bufn), 64'(b));
         chk({nm, "_addr"}, 64'(wlog[i].addr), 64'(a));
         chk({nm, "_data"}, wlog[i].data, d);
      end else begin
         chk({nm, "_missing"}, 64'(wlog.size()), 64'(i + 1));
      end
   endtask

   task automatic idle_sel0();
      bus.i_mem_sel = 1'b0;
      @(posedge i_clk); #1;
      @(posedge i_clk); #1;
      wlog.delete();
   endtask

   // Two rows of two words, elements 1..16, release of buffer 1 after element 10.
   task automatic run_basic(input bit gaps, input bit poke);
      int cyc, k, d0;
      idle_sel0();
      d0 = done_cnt;
      do_start(2, 2);
      fork
         feed(16, 1, gaps, 10, 400, cyc);
         if (poke) begin
            repeat (5) @(posedge i_clk);
            #1 bus.i_start = 1'b1;
            @(posedge i_clk); #1;
            bus.i_start = 1'b0;
         end
      join
      if (!gaps) chk("accept_cycles", 64'(cyc), 64'(17));
      wait_done(k);
      chk("done_latency", 64'(k), 64'(2));
      repeat (2) @(posedge i_clk);
      #1;
      chk("done_once", 64'(done_cnt - d0), 64'(1));
      chk("basic_nwrites", 64'(wlog.size()), 64'(4));
      chk_wr("b0", 0, 1, 0, 64'h0001_0002_0003_0004);
      chk_wr("b1", 1, 1, 1, 64'h0005_0006_0007_0008);
      chk_wr("b2", 2, 2, 0, 64'h0009_000A_000B_000C);
      chk_wr("b3", 3, 2, 1, 64'h000D_000E_000F_0010);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stim
      int cyc, k;
      i_rst_n = 1'b0;
      bus.i_start = 1'b0;
      bus.i_a_rows = '0;
      bus.i_a_cols_div_t = '0;
      bus.i_elem = '0;
      bus.i_elem_valid = 1'b0;
      bus.i_mem_sel = 1'b0;
      repeat (2) @(posedge i_clk);
      #3 i_rst_n = 1'b1;
      @(negedge i_clk);
      chk("rst_busy", 64'(bus.o_busy), 64'(0));
      chk("rst_done", 64'(bus.o_done), 64'(0));
      chk("rst_elem_ready", 64'(bus.o_elem_ready), 64'(0));
      chk("rst_a_ready", 64'(bus.o_a_ready), 64'(0));
      chk("rst_wr_en", 64'({bus.o_wr_en_1, bus.o_wr_en_2}), 64'(0));
      @(posedge i_clk); #1;

      // Basic packing and ping-pong
      run_basic(1'b0, 1'b0);

      // Ping-pong stall with i_mem_sel held 0
      idle_sel0();
      do_start(3, 2);
      fork
         feed(24, 1, 1'b0, 0, 300, cyc);
         begin
            int n;
            n = 0;
            while (acc_cnt < 16 && n < 200) begin @(posedge i_clk); #1; n++; end
            repeat (3) @(posedge i_clk);
            #1;
            @(negedge i_clk);
            chk("wait_ready_low", 64'(bus.o_elem_ready), 64'(0));
            chk("wait_a_ready", 64'(bus.o_a_ready), 64'(1));
            chk("wait_busy", 64'(bus.o_busy), 64'(1));
            @(posedge i_clk); #1;
            bus.i_mem_sel = 1'b1;
            @(negedge i_clk);
            chk("release_cycle_ready", 64'(bus.o_elem_ready), 64'(0));
            @(posedge i_clk); #1;
            @(negedge i_clk);
            chk("resume_ready", 64'(bus.o_elem_ready), 64'(1));
         end
      join
      wait_done(k);
      chk("stall_done_latency", 64'(k), 64'(2));
      chk("stall_nwrites", 64'(wlog.size()), 64'(6));
      chk_wr("s2", 2, 2, 0, 64'h0009_000A_000B_000C);
      chk_wr("s4", 4, 1, 0, 64'h0011_0012_0013_0014);
      chk_wr("s5", 5, 1, 1, 64'h0015_0016_0017_0018);

      // Valid gaps give the same words
      run_basic(1'b1, 1'b0);

      // Commit into buffer 2 coincides with i_mem_sel 0->1
      idle_sel0();
      do_start(2, 1);
      feed(8, 1, 1'b0, 8, 100, cyc);
      wait_done(k);
      chk("sim_done_latency", 64'(k), 64'(2));
      @(negedge i_clk);
      chk("sim_full2_a_ready", 64'(bus.o_a_ready), 64'(1));
      @(posedge i_clk); #1;
      bus.i_mem_sel = 1'b0;
      @(negedge i_clk);
      chk("sim_full1_clear", 64'(bus.o_a_ready), 64'(0));
      chk_wr("c0", 0, 1, 0, 64'h0001_0002_0003_0004);
      chk_wr("c1", 1, 2, 0, 64'h0005_0006_0007_0008);
      @(posedge i_clk); #1;

      // Reset mid-row
      idle_sel0();
      do_start(2, 2);
      feed(3, 1, 1'b0, 0, 50, cyc);
      chk("pre_reset_busy", 64'(bus.o_busy), 64'(1));
      #2 i_rst_n = 1'b0;
      #1;
      chk("arst_busy", 64'(bus.o_busy), 64'(0));
      chk("arst_done", 64'(bus.o_done), 64'(0));
      chk("arst_elem_ready", 64'(bus.o_elem_ready), 64'(0));
      chk("arst_a_ready", 64'(bus.o_a_ready), 64'(0));
      chk("arst_wr_en", 64'({bus.o_wr_en_1, bus.o_wr_en_2}), 64'(0));
      chk("arst_wr_data", bus.o_wr_data, 64'(0));
      @(negedge i_clk);
      @(posedge i_clk);
      #3 i_rst_n = 1'b1;
      @(posedge i_clk); #1;
      run_basic(1'b0, 1'b0);

      // i_start during FILL is ignored
      run_basic(1'b0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
